// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//   clog2      : constant-foldable ceil(log2(n)), returns 0 for n<=1
//   MODE_RR    : mode value selecting rotating priority
//   MODE_FIXED : mode value selecting highest-index-wins priority
//   state_e    : arbiter ownership state
package rr_arbiter_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {IDLE, GRANTED} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
//   enable, mode, req           : driven by the requester side (master)
//   gnt, gnt_idx, gnt_valid     : driven by the arbiter (slave)
interface rr_arbiter_if #(parameter int N = 8);

  localparam int IDX_W = (N > 1) ? rr_arbiter_pkg::clog2(N) : 1;

  logic             enable;
  logic             mode;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (output enable, mode, req, input gnt, gnt_idx, gnt_valid);
  modport slave  (input enable, mode, req, output gnt, gnt_idx, gnt_valid);

endinterface

// File: rtl/rr_arbiter_prio_enc_n.sv
// Width-N priority encoder.
//   vec    : input bit vector
//   onehot : single winning bit (zero when vec==0)
//   idx    : binary index of the winner (zero when vec==0)
//   valid  : |vec
// DIR=0 lets the lowest set index win, DIR=1 the highest.
module prio_enc_n #(
  parameter int N     = 8,
  parameter bit DIR   = 1'b0,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan so that the preferred end is visited last and overwrites.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (vec[DIR ? k : N-1-k]) begin
        onehot                  = '0;
        onehot[DIR ? k : N-1-k] = 1'b1;
        idx                     = IDX_W'(DIR ? k : N-1-k);
        valid                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, rotating or fixed priority
// and optional grant locking.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of rr_arbiter_if (enable/mode/req in,
//                gnt/gnt_idx/gnt_valid out, all outputs registered)
// Owner of a held grant is the registered gnt_idx.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N    = 8,
  parameter bit LOCK = 1'b0,
  localparam int IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;

  // Round-robin: lowest set bit at/above ptr, else lowest set bit overall.
  logic [N-1:0]     mask, req_m;
  logic [N-1:0]     m_oh, f_oh, h_oh, arb_oh;
  logic [IDX_W-1:0] m_idx, f_idx, h_idx, arb_idx;
  logic             m_vld, f_vld, h_vld, arb_vld;

  assign mask  = {N{1'b1}} << ptr_q;
  assign req_m = bus.req & mask;

  prio_enc_n #(.N(N), .DIR(1'b0), .IDX_W(IDX_W)) u_enc_masked (
    .vec(req_m), .onehot(m_oh), .idx(m_idx), .valid(m_vld));
  prio_enc_n #(.N(N), .DIR(1'b0), .IDX_W(IDX_W)) u_enc_full (
    .vec(bus.req), .onehot(f_oh), .idx(f_idx), .valid(f_vld));
  prio_enc_n #(.N(N), .DIR(1'b1), .IDX_W(IDX_W)) u_enc_high (
    .vec(bus.req), .onehot(h_oh), .idx(h_idx), .valid(h_vld));

  always_comb begin
    if (bus.mode == MODE_FIXED) begin
      arb_oh = h_oh; arb_idx = h_idx; arb_vld = h_vld;
    end else if (m_vld) begin
      arb_oh = m_oh; arb_idx = m_idx; arb_vld = 1'b1;
    end else begin
      arb_oh = f_oh; arb_idx = f_idx; arb_vld = f_vld;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    if (!bus.enable) begin
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end else if (LOCK && state_q == GRANTED && bus.req[idx_q]) begin
      // lock held: other requests are ignored, everything stays put
    end else if (arb_vld) begin
      state_d = GRANTED;
      gnt_d   = arb_oh;
      idx_d   = arb_idx;
      vld_d   = 1'b1;
      if (bus.mode == MODE_RR)
        ptr_d = (arb_idx == IDX_W'(N-1)) ? '0 : arb_idx + 1'b1;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;

endmodule
